// File: rtl/mux_stream_if.sv
// mux_stream_if: stream bundle for mux_stream; slave = mux side (in,in_valid,mode,select,out_ready in; in_ready,out,out_sel,out_valid[,out_parity] out), master = environment side; out_parity exists only with MUX_STREAM_PARITY_EN
interface mux_stream_if #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4
);
  localparam int SEL_W = $clog2(CHANNELS);
  logic [CHANNELS*WIDTH-1:0] in;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic                      mode;
  logic [SEL_W-1:0]          select;
  logic [WIDTH-1:0]          out;
  logic [SEL_W-1:0]          out_sel;
  logic                      out_valid;
  logic                      out_ready;
`ifdef MUX_STREAM_PARITY_EN
  logic                      out_parity;
  modport slave  (input in, in_valid, mode, select, out_ready, output in_ready, out, out_sel, out_valid, out_parity);
  modport master (output in, in_valid, mode, select, out_ready, input in_ready, out, out_sel, out_valid, out_parity);
`else
  modport slave  (input in, in_valid, mode, select, out_ready, output in_ready, out, out_sel, out_valid);
  modport master (output in, in_valid, mode, select, out_ready, input in_ready, out, out_sel, out_valid);
`endif
endinterface

// File: rtl/mux_stream.sv
// mux_stream: N-channel stream mux, manual or round-robin grant, registered output; ports clk, reset (sync high), bus (mux_stream_if.slave); MUX_STREAM_PARITY_EN adds registered even parity on bus.out_parity
module mux_stream #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4
) (
  input logic clk,
  input logic reset,
  mux_stream_if.slave bus
);
  localparam int SEL_W = $clog2(CHANNELS);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state, state_n;
  logic [SEL_W-1:0] ptr, gnt, rr_gnt, idx;
  logic [2**SEL_W-1:0] vpad;
  logic [WIDTH-1:0] ch [CHANNELS];
  logic [WIDTH-1:0] din;
  logic rr_hit, has_gnt, load, xfer;
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign ch[i] = bus.in[i*WIDTH +: WIDTH];
    assign bus.in_ready[i] = xfer && gnt == SEL_W'(i);
  end
  always_comb begin
    vpad = '0;
    vpad[CHANNELS-1:0] = bus.in_valid;
    rr_gnt = ptr;
    rr_hit = 1'b0;
    idx = ptr;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      idx = SEL_W'((int'(ptr) + k) % CHANNELS);
      if (bus.in_valid[idx]) begin
        rr_gnt = idx;
        rr_hit = 1'b1;
      end
    end
    gnt = bus.mode ? rr_gnt : bus.select;
    has_gnt = bus.mode ? rr_hit : vpad[bus.select];
    load = state == EMPTY || bus.out_ready;
    xfer = load && has_gnt && !reset;
    din = xfer ? ch[gnt] : '0;
    state_n = xfer ? FULL : (bus.out_ready ? EMPTY : state);
  end
  assign bus.out_valid = state == FULL;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      ptr <= '0;
      bus.out <= '0;
      bus.out_sel <= '0;
`ifdef MUX_STREAM_PARITY_EN
      bus.out_parity <= 1'b0;
`endif
    end else begin
      state <= state_n;
      if (xfer) begin
        bus.out <= din;
        bus.out_sel <= gnt;
`ifdef MUX_STREAM_PARITY_EN
        bus.out_parity <= ^din;
`endif
        if (bus.mode) ptr <= gnt == SEL_W'(CHANNELS - 1) ? '0 : gnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mux_stream.sv
// tb_mux_stream: directed self-checking bench for mux_stream
module tb_mux_stream;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_checks = 0;
  int n_errors = 0;
  mux_stream_if #(.WIDTH(4), .CHANNELS(4)) bus ();
  mux_stream #(.WIDTH(4), .CHANNELS(4)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.in = {4'hD, 4'hC, 4'hB, 4'hA};
    bus.in_valid = 4'b1111;
    bus.mode = 1'b0;
    bus.select = 2'd0;
    bus.out_ready = 1'b1;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'h0);
    step();
    check("rst_in_ready_1", 32'(bus.in_ready), 32'h0);
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_out", 32'(bus.out), 32'h0);
    check("rst_out_sel", 32'(bus.out_sel), 32'h0);
    step();
    check("rst_out_valid_2", 32'(bus.out_valid), 32'h0);
    reset = 1'b0;
    for (int s = 0; s < 4; s++) begin
      bus.select = 2'(s);
      #1;
      check($sformatf("man_in_ready_%0d", s), 32'(bus.in_ready), 32'(1 << s));
      step();
      check($sformatf("man_out_%0d", s), 32'(bus.out), 32'(4'hA + s));
      check($sformatf("man_sel_%0d", s), 32'(bus.out_sel), 32'(s));
      check($sformatf("man_valid_%0d", s), 32'(bus.out_valid), 32'h1);
    end
    bus.mode = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      check($sformatf("rr_sel_%0d", k), 32'(bus.out_sel), 32'(k % 4));
      check($sformatf("rr_out_%0d", k), 32'(bus.out), 32'(4'hA + k % 4));
      check($sformatf("rr_valid_%0d", k), 32'(bus.out_valid), 32'h1);
    end
    bus.in_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("skip_in_ready_%0d", k), 32'(bus.in_ready), (k % 2 == 0) ? 32'h2 : 32'h8);
      step();
      check($sformatf("skip_sel_%0d", k), 32'(bus.out_sel), (k % 2 == 0) ? 32'd1 : 32'd3);
    end
    bus.in_valid = 4'b1111;
    step();
    check("bp_load_out", 32'(bus.out), 32'hA);
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp_in_ready_%0d", k), 32'(bus.in_ready), 32'h0);
      step();
      check($sformatf("bp_out_%0d", k), 32'(bus.out), 32'hA);
      check($sformatf("bp_sel_%0d", k), 32'(bus.out_sel), 32'h0);
      check($sformatf("bp_valid_%0d", k), 32'(bus.out_valid), 32'h1);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 32'(bus.in_ready), 32'h2);
    step();
    check("bp_release_out", 32'(bus.out), 32'hB);
    check("bp_release_sel", 32'(bus.out_sel), 32'h1);
    bus.in_valid = 4'b0000;
    step();
    check("drain_valid", 32'(bus.out_valid), 32'h0);
    bus.in_valid = 4'b1111;
    bus.mode = 1'b0;
    bus.select = 2'd2;
    step();
    check("hold_load", 32'(bus.out), 32'hC);
    bus.out_ready = 1'b0;
    bus.mode = 1'b1;
    bus.select = 2'd3;
    step();
    check("hold_out", 32'(bus.out), 32'hC);
    check("hold_sel", 32'(bus.out_sel), 32'h2);
    bus.out_ready = 1'b1;
    bus.mode = 1'b0;
    bus.in = {4'hD, 4'h3, 4'hB, 4'hA};
    bus.select = 2'd1;
    step();
    check("par_out_b", 32'(bus.out), 32'hB);
`ifdef MUX_STREAM_PARITY_EN
    check("par_b", 32'(bus.out_parity), 32'h1);
`endif
    bus.select = 2'd2;
    step();
    check("par_out_3", 32'(bus.out), 32'h3);
`ifdef MUX_STREAM_PARITY_EN
    check("par_3", 32'(bus.out_parity), 32'h0);
`endif
    bus.select = 2'd1;
    reset = 1'b1;
    #1;
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'h0);
    step();
    check("mid_rst_valid", 32'(bus.out_valid), 32'h0);
    check("mid_rst_out", 32'(bus.out), 32'h0);
`ifdef MUX_STREAM_PARITY_EN
    check("mid_rst_par", 32'(bus.out_parity), 32'h0);
`endif
    reset = 1'b0;
    step();
    check("post_rst_out", 32'(bus.out), 32'hB);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mux_stream.md
Name: mux_stream

Overview:
- Parametrised successor to the 4:1 combinational MUX.
- N-channel, W-bit stream multiplexer with a registered output stage and valid/ready handshakes on every input and on the output.
- Two modes: manual channel select, and round-robin scan that skips idle channels.
- Sits between multiple producer streams and a single consumer, e.g. merging sensor or UART channels onto one bus.

Parameters:
WIDTH, 4, data width of each channel and of out
CHANNELS, 4, number of input channels (>= 2)
SEL_W, $clog2(CHANNELS), derived localparam, width of select/out_sel

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in  input  CHANNELS*WIDTH  packed channel data; channel i = in[i*WIDTH +: WIDTH]
in_valid  input  CHANNELS  per-channel data valid
in_ready  output  CHANNELS  per-channel accept (combinational)
mode  input  1  0 = manual select, 1 = round-robin scan
select  input  SEL_W  channel index used in manual mode
out  output  WIDTH  registered output data
out_sel  output  SEL_W  channel index that produced out
out_valid  output  1  out holds a valid word
out_ready  input  1  consumer accepts out

Behaviour:
- Clock and reset: single clock; reset is synchronous and active-high.
- Reset values: out=0, out_sel=0, out_valid=0, round-robin pointer ptr=0.
- Output stage states:
  - EMPTY (out_valid=0) or FULL (out_valid=1).
  - load = !out_valid || out_ready.
- Grant (combinational, evaluated each cycle):
  - Manual mode: gnt = select; a grant exists iff select < CHANNELS and in_valid[select]=1.
  - Round-robin mode: gnt = first i with in_valid[i]=1, searching ptr, ptr+1, …, CHANNELS-1, 0, …, ptr-1. A grant exists iff any in_valid bit is set.
- in_ready[i] = load && grant exists && gnt==i. At most one in_ready bit is high in a cycle.
- Transfer: in_valid[gnt] && in_ready[gnt]. On the next edge: out<=channel gnt data, out_sel<=gnt, out_valid<=1. Latency is 1 cycle from input acceptance to out_valid.
- Transitions:
  - EMPTY→FULL on transfer.
  - FULL→EMPTY when out_ready=1 and no transfer.
  - FULL→FULL with new data when out_ready=1 and a transfer occurs (back-to-back, 1 word/cycle).
  - FULL holds out, out_sel and out_valid stable while out_ready=0.
- ptr update: on a transfer in round-robin mode, ptr <= (gnt==CHANNELS-1) ? 0 : gnt+1. Otherwise ptr holds, including in manual mode.
- Mode or select changes take effect on the next grant and never alter a word already in the output register.
- Out-of-range select (>= CHANNELS, non-power-of-two CHANNELS only): no grant, all in_ready=0, out drains normally.
- Reset mid-operation: any FULL word is discarded, out_valid=0 on the cycle after reset, and in_ready stays 0 while reset is high.
- No combinational path from out_ready to out. The only combinational path from out_ready is to in_ready.

Optional Feature:
- Macro: MUX_STREAM_PARITY_EN.
- When defined: extra output port out_parity (1 bit) = even parity (^ of the loaded data word). It is registered alongside out, reset to 0, and holds with out.
- When undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: assert reset 2 cycles with all in_valid=1 → out_valid=0, out=0, out_sel=0, in_ready=0000 during reset.
- Manual select: mode=0, in={4'hD,4'hC,4'hB,4'hA} (ch0=A), in_valid=1111, out_ready=1, sweep select 0..3 → out=A,B,C,D one cycle after each change, out_sel matches select.
- Round-robin fairness: mode=1, in_valid=1111, out_ready=1 for 8 cycles → out_sel sequence 0,1,2,3,0,1,2,3 with out_valid continuously 1.
- Round-robin skip: mode=1, in_valid=1010 → out_sel alternates 1,3,1,3; in_ready[0] and in_ready[2] never high.
- Backpressure: FULL with out=A, drop out_ready for 3 cycles → out, out_sel and out_valid stable, in_ready=0000, ptr unchanged. Raise out_ready → next channel loads the following cycle.
- Parity (macro defined): load 4'hB then 4'h3 → out_parity=1 then 0. Reset mid-stream → out_parity=0 and out_valid=0.
